// File: rtl/ahb_mem_slave.sv
// AHB-Lite memory slave: small word-organised storage with configurable wait
// states and a two-cycle ERROR response for out-of-range or misaligned transfers.
module ahb_mem_slave #(
    parameter int unsigned WAIT_STATES = 1,
    parameter int unsigned DEPTH_LOG2  = 4
) (
    input  logic        hclk,
    input  logic        hreset,
    input  logic        hsel,
    input  logic [31:0] haddr,
    input  logic        hwrite,
    input  logic [2:0]  hsize,
    input  logic [2:0]  hburst,
    input  logic [3:0]  hprot,
    input  logic        hmastlock,
    input  logic [1:0]  htrans,
    input  logic        hready,
    input  logic [31:0] hwdata,
    output logic        hreadyout,
    output logic        hresp,
    output logic [31:0] hrdata
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned AW    = DEPTH_LOG2 + 2;
    localparam logic [1:0]  LAST_CNT = 2'(WAIT_STATES - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ERR1, S_ERR2} state_e;

    state_e          state_q, state_d;
    logic [1:0]      cnt_q, cnt_d;
    logic            act_q, act_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic            write_q, write_d;
    logic [1:0]      size_q, size_d;
    logic [31:0]     mem_q [DEPTH];

    logic                  accept_c;
    logic                  err_c;
    logic [3:0]            strb_c;
    logic [DEPTH_LOG2-1:0] idx_c;
    logic                  unused_c;

    assign unused_c = ^{hburst, hprot, hmastlock, htrans[0]};
    assign idx_c    = addr_q[AW-1:2];

    // Next-state, response decode and read mux; act_q marks a good completion cycle.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        act_d     = 1'b0;
        addr_d    = addr_q;
        write_d   = write_q;
        size_d    = size_q;
        hreadyout = !(state_q == S_WAIT || state_q == S_ERR1);
        hresp     = (state_q == S_ERR1 || state_q == S_ERR2);
        accept_c  = hsel & hready & htrans[1] & hreadyout;
        err_c     = (|haddr[31:AW]) || (hsize > 3'd2) ||
                    (hsize == 3'd1 && haddr[0]) ||
                    (hsize == 3'd2 && haddr[1:0] != 2'd0);

        case (state_q)
            S_WAIT: begin
                if (cnt_q == LAST_CNT) begin
                    state_d = S_IDLE;
                    cnt_d   = 2'd0;
                    act_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            S_ERR1: state_d = S_ERR2;
            default: begin
                state_d = S_IDLE;
                if (accept_c) begin
                    addr_d  = haddr[AW-1:0];
                    write_d = hwrite;
                    size_d  = hsize[1:0];
                    if (err_c) begin
                        state_d = S_ERR1;
                    end else if (WAIT_STATES == 0) begin
                        act_d = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = 2'd0;
                    end
                end
            end
        endcase

        case (size_q)
            2'd0:    strb_c = 4'b0001 << addr_q[1:0];
            2'd1:    strb_c = 4'b0011 << {addr_q[1], 1'b0};
            default: strb_c = 4'b1111;
        endcase

        hrdata = (act_q && !write_q) ? mem_q[idx_c] : 32'd0;
    end

    // State registers and storage; writes land on the edge ending completion.
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            state_q <= S_IDLE;
            cnt_q   <= 2'd0;
            act_q   <= 1'b0;
            addr_q  <= '0;
            write_q <= 1'b0;
            size_q  <= 2'd0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 32'd0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            act_q   <= act_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            size_q  <= size_d;
            if (act_q && write_q) begin
                for (int b = 0; b < 4; b++) begin
                    if (strb_c[b]) begin
                        mem_q[idx_c][8*b +: 8] <= hwdata[8*b +: 8];
                    end
                end
            end
        end
    end

endmodule
